// File: rtl/adder_tree_loader.sv
// Collects a stream of unsigned operands into 8-lane batches for the adder tree leaves.
// A batch closes when lane 7 is written or on flush; unwritten lanes are presented as zero.
module adder_tree_loader #(
    parameter int ADDER_WIDTH = 13,
    parameter int LANES       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDER_WIDTH-1:0]       in_data,
    input  logic                         in_flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*ADDER_WIDTH-1:0] out_data,
    output logic [3:0]                   out_count
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t                              r_state, w_state_nxt;
    logic [3:0]                          r_cnt, w_cnt_nxt;
    logic [LANES-1:0][ADDER_WIDTH-1:0]   r_lanes, w_lanes_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
            r_cnt   <= 4'd0;
            r_lanes <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lanes <= w_lanes_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lanes_nxt = r_lanes;
        in_ready    = 1'b1;
        out_valid   = 1'b0;
        case (r_state)
            S_FILL: begin
                if (in_valid) begin
                    w_lanes_nxt[r_cnt[2:0]] = in_data;
                    w_cnt_nxt               = r_cnt + 4'd1;
                    if (r_cnt == 4'(LANES - 1) || in_flush)
                        w_state_nxt = S_FULL;
                end else if (in_flush && r_cnt != 4'd0) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
                // Batch handoff: a same-cycle operand starts the next batch in lane 0.
                if (out_ready) begin
                    w_lanes_nxt = '0;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_FILL;
                    if (in_valid) begin
                        w_lanes_nxt[0] = in_data;
                        w_cnt_nxt      = 4'd1;
                        if (in_flush)
                            w_state_nxt = S_FULL;
                    end
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    assign out_data  = r_lanes;
    assign out_count = (r_state == S_FULL) ? r_cnt : 4'd0;

endmodule

// File: tb/tb_adder_tree_loader.sv
// Bench for adder_tree_loader: vector table, directed corner sequences and random traffic
// checked against a queue-based batch model.
module tb_adder_tree_loader;

    localparam int W = 13;
    localparam int L = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_flush;
    logic             out_valid;
    logic             out_ready;
    logic [L*W-1:0]   out_data;
    logic [3:0]       out_count;

    adder_tree_loader #(.ADDER_WIDTH(W), .LANES(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_flush  (in_flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    int n_tot  = 0;
    int n_pass = 0;

    // Reference: operands gathered so far, and the batch currently presented.
    logic [W-1:0] cur[$];
    logic [W-1:0] pres[$];
    bit           pres_v = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [L*W-1:0] pres_data();
        logic [L*W-1:0] e;
        e = '0;
        for (int k = 0; k < pres.size(); k++) e[k*W +: W] = pres[k];
        return e;
    endfunction

    // One clock: drive inputs, check in_ready, advance model, check outputs after the edge.
    task automatic step(input bit v, input logic [W-1:0] d, input bit f, input bit o, input bit r);
        bit rdy;
        bit ix;
        in_valid  = v;
        in_data   = d;
        in_flush  = f;
        out_ready = o;
        rst       = r;
        #1;
        rdy = !pres_v || o;
        ix  = v && rdy;
        if (!r) chk("in_ready", 128'(in_ready), 128'(rdy));
        @(posedge clk);
        if (r) begin
            cur.delete();
            pres.delete();
            pres_v = 1'b0;
        end else begin
            if (pres_v && o) begin
                pres_v = 1'b0;
                pres.delete();
            end
            if (ix) cur.push_back(d);
            if (cur.size() == L || (f && cur.size() > 0)) begin
                pres   = cur;
                pres_v = 1'b1;
                cur.delete();
            end
        end
        #1;
        chk("out_valid", 128'(out_valid), 128'(pres_v));
        if (pres_v) begin
            chk("out_data", 128'(out_data), 128'(pres_data()));
            chk("out_count", 128'(out_count), 128'(pres.size()));
        end else if (r) begin
            chk("rst_out_data", 128'(out_data), 128'(0));
            chk("rst_out_count", 128'(out_count), 128'(0));
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit           v;
        logic [W-1:0] d;
        bit           f;
        bit           o;
        bit           e_ov;
        logic [3:0]   e_cnt;
        logic [W-1:0] e_l0;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [L*W-1:0] exp_d;
        int             pulses[$];
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        step(0, 0, 0, 0, 1);

        // Vector table: short flushed batch, ignored empty flush, full batch, flush on handoff.
        tbl.push_back('{1, 13'h1FFF, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 13'h0001, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 13'h0AAA, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 13'h0000, 1, 1, 1, 3, 13'h1FFF});
        tbl.push_back('{0, 13'h0000, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 13'h0000, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 13'h0000, 0, 1, 0, 0, 0});
        for (int i = 0; i < L; i++)
            tbl.push_back('{1, 13'(13'h100 + i), 0, 1, (i == L-1), 8, 13'h100});
        tbl.push_back('{1, 13'h0123, 1, 1, 1, 1, 13'h0123});
        tbl.push_back('{0, 13'h0000, 0, 1, 0, 0, 0});
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].o, 0);
            chk("tbl_ov", 128'(out_valid), 128'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk("tbl_cnt", 128'(out_count), 128'(tbl[i].e_cnt));
                chk("tbl_lane0", 128'(out_data[W-1:0]), 128'(tbl[i].e_l0));
                if (tbl[i].e_cnt == 4'd1)
                    chk("tbl_lanes_hi", 128'(out_data[L*W-1:W]), 128'(0));
            end
        end

        // Eight back-to-back operands 1..8 form one batch, then out_valid drops.
        step(0, 0, 0, 1, 1);
        for (int i = 1; i <= L; i++) step(1, 13'(i), 0, 1, 0);
        exp_d = '0;
        for (int k = 0; k < L; k++) exp_d[k*W +: W] = 13'(k + 1);
        chk("b8_data", 128'(out_data), 128'(exp_d));
        chk("b8_count", 128'(out_count), 128'(8));
        step(0, 0, 0, 1, 0);
        chk("b8_drop", 128'(out_valid), 128'(0));

        // Backpressure: batch held for 5 cycles while in_valid keeps trying.
        for (int i = 0; i < L; i++) step(1, 13'(13'h0A00 + i), 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 13'h1555, 0, 0, 0);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        step(0, 0, 0, 1, 0);
        chk("bp_release", 128'(in_ready), 128'(1));

        // 24 continuous operands: three full batches 8 cycles apart.
        for (int i = 0; i < 3*L + 1; i++) begin
            step(i < 3*L, 13'($urandom_range(0, 8191)), 0, 1, 0);
            if (out_valid) pulses.push_back(i);
        end
        chk("stream_pulses", 128'(pulses.size()), 128'(3));
        if (pulses.size() == 3) begin
            chk("stream_gap1", 128'(pulses[1] - pulses[0]), 128'(8));
            chk("stream_gap2", 128'(pulses[2] - pulses[1]), 128'(8));
        end

        // Reset mid-batch discards partial data, even with a transfer offered.
        for (int i = 0; i < 5; i++) step(1, 13'(13'h0700 + i), 0, 1, 0);
        step(1, 13'h1234, 0, 1, 1);
        for (int i = 0; i < L; i++) step(1, 13'(13'h0050 + i), 0, 1, 0);
        chk("post_rst_lane0", 128'(out_data[W-1:0]), 128'(13'h0050));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 3) != 0), 13'($urandom_range(0, 8191)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 7), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
